// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: UART command front end. Receives bytes on RX, pairs them
// into a 16-bit command (high byte first) and serializes response bytes on TX.
// Ports: clk, rst (sync, active-high), RX/TX serial lines, cmd/cmd_rdy with
// clr_cmd_rdy handshake, resp/send_resp/resp_sent/tx_busy for the response
// path, frame_err pulse on a bad stop bit.
// Build option: define CMD_TIMEOUT_EN to drop a stale high byte after TIMEOUT
// cycles in WAIT_LO; otherwise WAIT_LO waits indefinitely.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 5208,
  parameter int TIMEOUT  = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frame_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);

  // Elaboration-time guard on the configuration.
  if (BAUD_DIV < 16 || TIMEOUT < 2) begin : g_bad_cfg
    $error("uart_cmd_wrapper: BAUD_DIV must be >= 16, TIMEOUT >= 2");
  end

  // ---------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  rx_state_e       rx_st_q, rx_st_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_st_q      <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_s1_q      <= RX;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_st_q      <= rx_st_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sh_q      <= rx_sh_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_st_d      = rx_st_q;
    rx_cnt_d     = rx_cnt_q + 1'b1;
    rx_bit_d     = rx_bit_q;
    rx_sh_d      = rx_sh_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        // Falling edge on the synchronized line marks a start bit.
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d = R_START;
        end
      end
      R_START: begin
        if (rx_cnt_q == BAUD_HALF) begin
          rx_cnt_d = '0;
          rx_st_d  = rx_s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 4'd7) begin
            rx_bit_d = '0;
            rx_st_d  = R_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d     = '0;
          byte_valid_d = rx_s2_q;
          frame_err_d  = !rx_s2_q;
          rx_st_d      = R_IDLE;
        end
      end
      default: begin
        rx_st_d = R_IDLE;
      end
    endcase
  end

  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------
  // Command assembler
  // ---------------------------------------------------------------
  typedef enum logic {
    A_WAIT_HI,
    A_WAIT_LO
  } asm_state_e;

  asm_state_e  asm_st_q, asm_st_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_q, to_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end

  // Counts only while staying in WAIT_LO; any entry starts from zero.
  always_comb begin
    to_d = '0;
    if (asm_st_q == A_WAIT_LO && asm_st_d == A_WAIT_LO) begin
      to_d = to_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_st_q  <= A_WAIT_HI;
      hi_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      asm_st_q  <= asm_st_d;
      hi_q      <= hi_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  always_comb begin
    asm_st_d  = asm_st_q;
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end
    unique case (asm_st_q)
      A_WAIT_HI: begin
        if (byte_valid_q) begin
          hi_d      = rx_sh_q;
          cmd_rdy_d = 1'b0;
          asm_st_d  = A_WAIT_LO;
        end
      end
      A_WAIT_LO: begin
        // A completion overrides a same-cycle clear.
        if (byte_valid_q) begin
          cmd_d     = {hi_q, rx_sh_q};
          cmd_rdy_d = 1'b1;
          asm_st_d  = A_WAIT_HI;
        end
`ifdef CMD_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          hi_d     = '0;
          asm_st_d = A_WAIT_HI;
        end
`endif
      end
      default: begin
        asm_st_d = A_WAIT_HI;
      end
    endcase
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  // ---------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {
    T_IDLE,
    T_SHIFT,
    T_DONE
  } tx_state_e;

  tx_state_e     tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_sh_q, tx_sh_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= T_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    unique case (tx_st_q)
      T_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (send_resp) begin
          tx_sh_d = {1'b1, resp, 1'b0};
          tx_st_d = T_SHIFT;
        end
      end
      T_SHIFT: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            tx_st_d  = T_DONE;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      T_DONE: begin
        tx_cnt_d = '0;
        tx_st_d  = T_IDLE;
      end
      default: begin
        tx_cnt_d = '0;
        tx_st_d  = T_IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state; line idles high.
  assign TX        = (tx_st_q == T_SHIFT) ? tx_sh_q[0] : 1'b1;
  assign tx_busy   = (tx_st_q == T_SHIFT);
  assign resp_sent = (tx_st_q == T_DONE);

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper: directed self-checking bench for uart_cmd_wrapper
// at BAUD_DIV=16, TIMEOUT=200.
module tb_uart_cmd_wrapper;

  localparam int BD = 16;
  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        resp_sent;
  logic        tx_busy;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int rs_cnt = 0;

  uart_cmd_wrapper #(
    .BAUD_DIV(BD),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .RX(RX),
    .TX(TX),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp(resp),
    .send_resp(send_resp),
    .resp_sent(resp_sent),
    .tx_busy(tx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (resp_sent) rs_cnt <= rs_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    cyc(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      cyc(BD);
    end
    RX = stop;
    cyc(BD);
    RX = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    checks++;
    if (TX !== 1'b1) begin
      errors++; $display("FAIL reset_tx: got %b expected 1", TX);
    end
    checks++;
    if (cmd !== 16'h0000) begin
      errors++; $display("FAIL reset_cmd: got %h expected 0000", cmd);
    end
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy);
    end
    checks++;
    if (resp_sent !== 1'b0) begin
      errors++; $display("FAIL reset_resp_sent: got %b expected 0", resp_sent);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err);
    end
    rst = 1'b0;
    cyc(3);
  endtask

  task automatic test_cmd_assembly;
    send_byte(8'h40, 1'b1);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL asm_half: got cmd_rdy %b expected 0", cmd_rdy);
    end
    send_byte(8'h00, 1'b1);
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL asm_rdy_rise: got %b expected 1", cmd_rdy);
    end
    checks++;
    if (cmd !== 16'h4000) begin
      errors++; $display("FAIL asm_cmd: got %h expected 4000", cmd);
    end
    cyc(5);
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL asm_rdy_hold: got %b expected 1", cmd_rdy);
    end
    clr_cmd_rdy = 1'b1;
    cyc(1);
    clr_cmd_rdy = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL asm_clr: got %b expected 0", cmd_rdy);
    end
    checks++;
    if (cmd !== 16'h4000) begin
      errors++; $display("FAIL asm_cmd_hold: got %h expected 4000", cmd);
    end
  endtask

  task automatic test_tx;
    logic [9:0] fr;
    int rs0;
    int idx;
    fr = {1'b1, 8'hA5, 1'b0};
    rs0 = rs_cnt;
    resp = 8'hA5;
    send_resp = 1'b1;
    for (int i = 1; i <= 162; i++) begin
      cyc(1);
      send_resp = (i == 50);
      if (i == 50) resp = 8'h00;
      if (i <= 160) begin
        idx = (i - 1) / BD;
        checks++;
        if (TX !== fr[idx]) begin
          errors++;
          $display("FAIL tx_bit cyc %0d: got %b expected %b", i, TX, fr[idx]);
        end
        if (i == 1 || i == 160) begin
          checks++;
          if (tx_busy !== 1'b1 || resp_sent !== 1'b0) begin
            errors++;
            $display("FAIL tx_busy cyc %0d: got busy %b sent %b expected 1 0",
                     i, tx_busy, resp_sent);
          end
        end
      end else if (i == 161) begin
        checks++;
        if (resp_sent !== 1'b1 || tx_busy !== 1'b0 || TX !== 1'b1) begin
          errors++;
          $display("FAIL tx_done: got sent %b busy %b tx %b expected 1 0 1",
                   resp_sent, tx_busy, TX);
        end
      end else begin
        checks++;
        if (resp_sent !== 1'b0 || tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL tx_after: got sent %b busy %b expected 0 0",
                   resp_sent, tx_busy);
        end
      end
    end
    cyc(20);
    checks++;
    if (rs_cnt !== rs0 + 1) begin
      errors++; $display("FAIL tx_sent_count: got %0d expected %0d", rs_cnt, rs0 + 1);
    end
    checks++;
    if (TX !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL tx_idle: got tx %b busy %b expected 1 0", TX, tx_busy);
    end
  endtask

  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h23, 1'b0);
    cyc(20);
    checks++;
    if (fe_cnt !== fe0 + 1) begin
      errors++; $display("FAIL fe_count: got %0d expected %0d", fe_cnt, fe0 + 1);
    end
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL fe_cmd_rdy: got %b expected 0", cmd_rdy);
    end
    send_byte(8'h23, 1'b1);
    send_byte(8'hFF, 1'b1);
    cyc(2);
    checks++;
    if (cmd !== 16'h23FF || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL fe_recover: got %h rdy %b expected 23FF 1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_glitch;
    int fe0;
    fe0 = fe_cnt;
    RX = 1'b0;
    cyc(5);
    RX = 1'b1;
    cyc(40);
    checks++;
    if (fe_cnt !== fe0) begin
      errors++; $display("FAIL glitch_fe: got %0d expected %0d", fe_cnt, fe0);
    end
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h23FF) begin
      errors++; $display("FAIL glitch_cmd: got %h rdy %b expected 23FF 1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_coincident_clr;
    int hi;
    hi = 0;
    clr_cmd_rdy = 1'b1;
    cyc(1);
    clr_cmd_rdy = 1'b0;
    send_byte(8'h12, 1'b1);
    fork
      send_byte(8'h34, 1'b1);
      begin
        cyc(140);
        clr_cmd_rdy = 1'b1;
        repeat (30) begin
          cyc(1);
          if (cmd_rdy === 1'b1) hi++;
        end
        clr_cmd_rdy = 1'b0;
      end
    join
    checks++;
    if (hi !== 1) begin
      errors++; $display("FAIL coincident_set: got %0d rdy cycles expected 1", hi);
    end
    checks++;
    if (cmd !== 16'h1234) begin
      errors++; $display("FAIL coincident_cmd: got %h expected 1234", cmd);
    end
    cyc(1);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL coincident_after: got %b expected 0", cmd_rdy);
    end
  endtask

  task automatic test_reset_mid;
    int rs0;
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    cyc(2);
    checks++;
    if (cmd !== 16'h55AA || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL rm_pre: got %h rdy %b expected 55AA 1", cmd, cmd_rdy);
    end
    resp = 8'h3C;
    send_resp = 1'b1;
    RX = 1'b0;
    cyc(1);
    send_resp = 1'b0;
    cyc(40);
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++; $display("FAIL rm_busy: got %b expected 1", tx_busy);
    end
    rs0 = rs_cnt;
    rst = 1'b1;
    RX = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++;
    if (TX !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL rm_tx: got tx %b busy %b expected 1 0", TX, tx_busy);
    end
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h0000) begin
      errors++; $display("FAIL rm_cmd: got %h rdy %b expected 0000 0", cmd, cmd_rdy);
    end
    cyc(200);
    checks++;
    if (rs_cnt !== rs0) begin
      errors++; $display("FAIL rm_no_sent: got %0d expected %0d", rs_cnt, rs0);
    end
    send_byte(8'h40, 1'b1);
    send_byte(8'h02, 1'b1);
    cyc(2);
    checks++;
    if (cmd !== 16'h4002 || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL rm_fresh: got %h rdy %b expected 4002 1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_timeout;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
`ifdef CMD_TIMEOUT_EN
    exp_cmd = 16'h27FF;
    exp_rdy = 1'b1;
`else
    exp_cmd = 16'h4027;
    exp_rdy = 1'b0;
`endif
    send_byte(8'h40, 1'b1);
    cyc(250);
    send_byte(8'h27, 1'b1);
    send_byte(8'hFF, 1'b1);
    cyc(2);
    checks++;
    if (cmd !== exp_cmd) begin
      errors++; $display("FAIL timeout_cmd: got %h expected %h", cmd, exp_cmd);
    end
    checks++;
    if (cmd_rdy !== exp_rdy) begin
      errors++; $display("FAIL timeout_rdy: got %b expected %b", cmd_rdy, exp_rdy);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_cmd_assembly;
    test_tx;
    test_frame_err;
    test_glitch;
    test_coincident_clr;
    test_reset_mid;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
